inv_sub_bytes: RTL and testbench
================================

INV_SUB_BYTES -- requirements
Module: inv_sub_bytes

Interface
REQ-001 Parameters: none; lane count is fixed by the Configuration macro only.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  in_state holds a 128-bit AES state to be inverse-substituted.
REQ-005 in_ready  output  1  block accepts a state this cycle.
REQ-006 in_state  input  128  byte i (i=0..15) = in_state[127-8i -: 8], i.e. byte 0 is the MSB byte.
REQ-007 out_valid  output  1  out_state holds a complete result.
REQ-008 out_ready  input  1  consumer accepts out_state this cycle.
REQ-009 out_state  output  128  InvSubBytes(in_state), same byte ordering as in_state.
REQ-010 busy  output  1  high in every state except IDLE.

Function
REQ-011 Each output byte SHALL equal the FIPS-197 inverse S-box of the corresponding input byte.
REQ-012 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-013 IDLE: in_ready=1. On in_valid&&in_ready, capture in_state into an internal register, clear byte index to 0, go to RUN.
REQ-014 RUN: each cycle present the next group of L bytes (L=1 default) to the lookup and advance the index by L. After the last group is presented, go to DRAIN.
REQ-015 The lookup SHALL be registered with 1-cycle latency. Each lookup result SHALL be written into out_state the cycle after presentation.
REQ-016 DRAIN: write the final group, go to DONE.
REQ-017 DONE: out_valid=1; on out_valid&&out_ready go to IDLE.
REQ-018 Latency (L=1): out_valid SHALL rise exactly 17 cycles after the accepting edge.
REQ-019 in_ready SHALL be 0 in RUN, DRAIN and DONE. in_valid in those states SHALL be ignored. No input is accepted in the same cycle as an output handshake.
REQ-020 out_state SHALL remain stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-021 Changes to in_state after the accepting edge SHALL have no effect on the result.
REQ-022 out_ready while out_valid=0 SHALL have no effect.
REQ-023 The byte index SHALL be 4 bits and SHALL never wrap within one operation.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, busy=0, out_state=0, index=0.
REQ-025 Reset during RUN, DRAIN or DONE SHALL discard the partial or pending result, with no output handshake.
REQ-026 Lookup tables SHALL be constant and unaffected by reset.

Configuration
REQ-027 Macro INV_SUB_BYTES_FAST_EN defined: L=4 lanes, 4 lookup instances, 4 RUN cycles, out_valid 5 cycles after the accepting edge.
REQ-028 Macro INV_SUB_BYTES_FAST_EN undefined: L=1, a single lookup instance, latency per REQ-018.
REQ-029 Function, handshake and reset behaviour SHALL be otherwise identical in both builds.

Structure
REQ-030 Shared package aes_pkg SHALL hold AES_BYTE_W=8, AES_STATE_W=128, AES_NUM_BYTES=16, and the FSM state enum typedef.
REQ-031 Sub-module inv_sbox (ports clk, byte_in[7:0], byte_out[7:0]) SHALL hold the 256-entry inverse table and register its output on posedge clk. It has no reset.

Verification
REQ-032 in_state=637c777bf26b6fc53001672bfed7ab76 -> out_state=000102030405060708090a0b0c0d0e0f, out_valid at cycle 17 (cycle 5 with FAST).
REQ-033 in_state all 0x63 -> all 0x00; in_state all 0x00 -> all 0x52; in_state all 0x16 -> all 0xFF.
REQ-034 out_ready held low 50 cycles after out_valid -> out_state and out_valid unchanged; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-035 in_valid held high with changing in_state during RUN -> result reflects only the accepted state, and exactly one result is produced.
REQ-036 rst_n pulsed low at RUN cycle 8 -> out_valid=0, out_state=0, in_ready=1 immediately; the next accepted state completes correctly.
REQ-037 All 256 byte values across 16 back-to-back operations -> every byte matches the inverse S-box; a forward S-box model round-trips each byte.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: byte/state widths and the inverse-substitution
// sequencer state type used by inv_sub_bytes.
package aes_pkg;

  localparam int AES_BYTE_W    = 8;
  localparam int AES_STATE_W   = 128;
  localparam int AES_NUM_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } isb_state_t;

endpackage

// File: rtl/inv_sbox.sv
// FIPS-197 inverse S-box lookup with a registered output.
// The table is a constant; the output register has no reset.
module inv_sbox
  import aes_pkg::*;
(
  input  logic                  clk,
  input  logic [AES_BYTE_W-1:0] byte_in,
  output logic [AES_BYTE_W-1:0] byte_out
);

  localparam logic [AES_BYTE_W-1:0] INV_TABLE [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Register the table output so the lookup is one cycle deep.
  always_ff @(posedge clk) begin
    byte_out <= INV_TABLE[byte_in];
  end

endmodule

// File: rtl/inv_sub_bytes.sv
// InvSubBytes over a 128-bit AES state, processed a group of bytes per cycle
// through registered inverse S-box lanes.
// Build option: define INV_SUB_BYTES_FAST_EN for 4 lanes (4 RUN cycles);
// by default a single lane walks all 16 bytes.
module inv_sub_bytes
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state,
  output logic                   busy
);

`ifdef INV_SUB_BYTES_FAST_EN
  localparam int LANES = 4;
`else
  localparam int LANES = 1;
`endif
  localparam logic [3:0] STEP     = 4'(LANES);
  localparam logic [3:0] LAST_IDX = 4'(AES_NUM_BYTES - LANES);

  isb_state_t             state;
  isb_state_t             next_state;
  logic [AES_STATE_W-1:0] hold_state;
  logic [3:0]             idx;
  logic [3:0]             wr_idx;
  logic                   wr_pend;
  logic                   accept;
  logic [AES_BYTE_W-1:0]  lut_in  [LANES];
  logic [AES_BYTE_W-1:0]  lut_out [LANES];
  logic [3:0]             wr_pos  [LANES];

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    inv_sbox u_inv_sbox (
      .clk      (clk),
      .byte_in  (lut_in[g]),
      .byte_out (lut_out[g])
    );
  end

  // State register; reset returns to IDLE and drops any pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: RUN ends after the last group is presented, DRAIN catches its write.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = RUN;
      RUN:     if (idx == LAST_IDX) next_state = DRAIN;
      DRAIN:   next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Select the current byte group from the captured state and the write positions one cycle later.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      lut_in[j] = '0;
      wr_pos[j] = wr_idx + 4'(j);
      for (int b = 0; b < AES_NUM_BYTES; b++) begin
        if ((idx + 4'(j)) == 4'(b)) begin
          lut_in[j] = hold_state[AES_STATE_W-1-AES_BYTE_W*b -: AES_BYTE_W];
        end
      end
    end
  end

  // Capture input, walk the byte index, and merge lookup results into out_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_state <= '0;
      idx        <= '0;
      wr_idx     <= '0;
      wr_pend    <= 1'b0;
      out_state  <= '0;
    end else begin
      wr_pend <= (state == RUN);
      wr_idx  <= idx;
      if (accept) begin
        hold_state <= in_state;
        idx        <= '0;
      end else if ((state == RUN) && (idx != LAST_IDX)) begin
        idx <= idx + STEP;
      end
      for (int b = 0; b < AES_NUM_BYTES; b++) begin
        for (int j = 0; j < LANES; j++) begin
          if (wr_pend && (wr_pos[j] == 4'(b))) begin
            out_state[AES_STATE_W-1-AES_BYTE_W*b -: AES_BYTE_W] <= lut_out[j];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes.sv
// Self-checking bench for inv_sub_bytes. The reference S-box is derived
// arithmetically (GF(2^8) inverse plus affine map) and inverted into a table;
// a cycle model predicts handshakes, latency and the result.
module tb_inv_sub_bytes;

`ifdef INV_SUB_BYTES_FAST_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 17;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int n_compared   = 0;
  int n_mismatched = 0;
  int n_results    = 0;
  int cyc          = 0;
  int acc_cyc      = 0;
  bit m_busy       = 0;
  bit check_en     = 0;
  logic [127:0] m_exp = '0;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  inv_sub_bytes dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; zero maps to zero.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 254; i++) r = gf_mul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] exp_inv(input logic [127:0] st);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = inv_tab[st[127-8*i -: 8]];
    return r;
  endfunction

  task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic report_timeout(input string name);
    n_compared++;
    n_mismatched++;
    $display("[TB] FAIL %s: timed out", name);
  endtask

  // Cycle model: accepts when idle, result due LAT cycles later, released on out_ready.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
    end else if (m_busy && (cyc - acc_cyc >= LAT)) begin
      if (out_ready) begin
        m_busy = 1'b0;
        n_results++;
      end
    end else if (!m_busy && in_valid) begin
      m_busy  = 1'b1;
      m_exp   = exp_inv(in_state);
      acc_cyc = cyc + 1;
    end
    cyc++;
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (rst_n && check_en) begin
      check_output("in_ready", {127'd0, in_ready}, {127'd0, !m_busy});
      check_output("busy", {127'd0, busy}, {127'd0, m_busy});
      check_output("out_valid", {127'd0, out_valid}, {127'd0, m_busy && (cyc - acc_cyc >= LAT)});
      if (m_busy && (cyc - acc_cyc >= LAT)) check_output("out_state", out_state, m_exp);
    end
  end

  task automatic apply_stimulus(input logic [127:0] st);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) report_timeout("in_ready wait");
    in_valid = 1'b1;
    in_state = st;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output logic [127:0] got);
    int n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) report_timeout("out_valid wait");
    got = out_state;
  endtask

  task automatic run_op(input string name, input logic [127:0] st, input logic [127:0] expected);
    logic [127:0] got;
    apply_stimulus(st);
    wait_result(got);
    check_output(name, got, expected);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] got, snap, st, rt;
    int r0;
    bit bad;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_state  = '0;
    for (int x = 0; x < 256; x++) fwd_tab[x] = fwd_sbox(8'(x));
    for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);

    check_output("model fwd 00", {120'd0, fwd_tab[8'h00]}, 128'h63);
    check_output("model fwd 01", {120'd0, fwd_tab[8'h01]}, 128'h7c);
    check_output("model inv 63", {120'd0, inv_tab[8'h63]}, 128'h00);
    check_output("model inv 00", {120'd0, inv_tab[8'h00]}, 128'h52);
    check_output("model inv 16", {120'd0, inv_tab[8'h16]}, 128'hff);

    #12;
    check_output("reset out_valid", {127'd0, out_valid}, 128'd0);
    check_output("reset in_ready", {127'd0, in_ready}, 128'd1);
    check_output("reset busy", {127'd0, busy}, 128'd0);
    check_output("reset out_state", out_state, 128'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    check_en = 1'b1;

    run_op("fips vector", 128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f);
    run_op("all 63", {16{8'h63}}, {16{8'h00}});
    run_op("all 00", {16{8'h00}}, {16{8'h52}});
    run_op("all 16", {16{8'h16}}, {16{8'hff}});

    r0 = n_results;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    out_ready = 1'b0;
    check_output("idle out_ready results", 128'(n_results), 128'(r0));

    apply_stimulus(128'h0123456789abcdeffedcba9876543210);
    wait_result(snap);
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_state !== snap) bad = 1'b1;
    end
    check_output("backpressure hold", {127'd0, bad}, 128'd0);
    check_output("backpressure data", snap, exp_inv(128'h0123456789abcdeffedcba9876543210));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_output("release in_ready", {127'd0, in_ready}, 128'd1);
    check_output("release out_valid", {127'd0, out_valid}, 128'd0);

    r0 = n_results;
    st = 128'hdeadbeef00112233445566778899aabb;
    in_valid = 1'b1;
    in_state = st;
    for (int n = 0; n < 100 && !out_valid; n++) begin
      @(negedge clk);
      in_state = {$urandom, $urandom, $urandom, $urandom};
    end
    in_valid = 1'b0;
    check_output("busy ignore data", out_state, exp_inv(st));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    repeat (5) @(negedge clk);
    check_output("busy ignore count", 128'(n_results), 128'(r0 + 1));

    r0 = n_results;
    apply_stimulus(128'h00112233445566778899aabbccddeeff);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("midrun reset out_valid", {127'd0, out_valid}, 128'd0);
    check_output("midrun reset out_state", out_state, 128'd0);
    check_output("midrun reset in_ready", {127'd0, in_ready}, 128'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_output("midrun reset count", 128'(n_results), 128'(r0));
    run_op("after reset", 128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f);

    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 16; i++) st[127-8*i -: 8] = 8'(((k * 16 + i) * 7) + 3);
      apply_stimulus(st);
      wait_result(got);
      check_output("sweep result", got, exp_inv(st));
      for (int i = 0; i < 16; i++) rt[127-8*i -: 8] = fwd_tab[got[127-8*i -: 8]];
      check_output("sweep roundtrip", rt, st);
      @(negedge clk);
    end
    out_ready = 1'b0;

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
